// File: rtl/rs485_uart_rx.sv
// RS485 UART receiver: 8 data bits, optional parity, one stop bit, delivered
// on a single-entry valid/ready buffer with frame, parity and overrun pulses.
module rs485_uart_rx #(
  parameter int g_CyclesPerBit = 868,
  parameter int g_Parity       = 0
) (
  input  logic       clk_ik,
  input  logic       rst_ir,
  input  logic       rx_i,
  output logic [7:0] data_ob,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int            TW        = $clog2(g_CyclesPerBit);
  localparam logic [TW-1:0] BIT_LAST  = TW'(g_CyclesPerBit - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(g_CyclesPerBit / 2 - 1);
  localparam logic          PAR_EN    = (g_Parity != 0);
  localparam logic          PAR_ODD   = (g_Parity == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic          parity_ok_reg, parity_ok_next;
  logic [7:0]    data_reg, data_next;
  logic          valid_reg, valid_next;
  logic          frame_err_reg, frame_err_next;
  logic          parity_err_reg, parity_err_next;
  logic          overrun_reg, overrun_next;
  logic          sync1_reg, rx_s_reg, rx_d_reg;
  logic [1:0]    warm_reg;
  logic          bit_done;

  // The synchroniser resets high, so the first real line sample can look like
  // a falling edge; edge detection stays disarmed until rx_d holds a real sample.
  always_ff @(posedge clk_ik) begin
    if (rst_ir) begin
      sync1_reg      <= 1'b1;
      rx_s_reg       <= 1'b1;
      rx_d_reg       <= 1'b1;
      warm_reg       <= 2'd0;
      state_reg      <= IDLE;
      timer_reg      <= '0;
      bit_cnt_reg    <= 3'd0;
      shift_reg      <= 8'd0;
      parity_ok_reg  <= 1'b1;
      data_reg       <= 8'd0;
      valid_reg      <= 1'b0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      sync1_reg      <= rx_i;
      rx_s_reg       <= sync1_reg;
      rx_d_reg       <= rx_s_reg;
      warm_reg       <= (warm_reg == 2'd3) ? 2'd3 : warm_reg + 2'd1;
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      parity_ok_reg  <= parity_ok_next;
      data_reg       <= data_next;
      valid_reg      <= valid_next;
      frame_err_reg  <= frame_err_next;
      parity_err_reg <= parity_err_next;
      overrun_reg    <= overrun_next;
    end
  end

  assign bit_done = (timer_reg == BIT_LAST);

  always_comb begin
    state_next      = state_reg;
    timer_next      = timer_reg + TW'(1);
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    parity_ok_next  = parity_ok_reg;
    data_next       = data_reg;
    valid_next      = valid_reg & ~ready_i;
    frame_err_next  = 1'b0;
    parity_err_next = 1'b0;
    overrun_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        timer_next     = '0;
        parity_ok_next = 1'b1;
        if (warm_reg == 2'd3 && rx_d_reg && !rx_s_reg) begin
          state_next = START;
        end
      end
      START: begin
        if (timer_reg == HALF_LAST) begin
          timer_next   = '0;
          bit_cnt_next = 3'd0;
          state_next   = rx_s_reg ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          timer_next = '0;
          shift_next = {rx_s_reg, shift_reg[7:1]};
          if (bit_cnt_reg == 3'd7) begin
            state_next = PAR_EN ? PARITY : STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          timer_next     = '0;
          parity_ok_next = (rx_s_reg == ((^shift_reg) ^ PAR_ODD));
          state_next     = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          timer_next      = '0;
          state_next      = IDLE;
          frame_err_next  = ~rx_s_reg;
          parity_err_next = ~parity_ok_reg;
          if (rx_s_reg && parity_ok_reg) begin
            // A consume in the same cycle frees the slot for the new byte.
            if (!valid_reg || ready_i) begin
              data_next  = shift_reg;
              valid_next = 1'b1;
            end else begin
              overrun_next = 1'b1;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign data_ob      = data_reg;
  assign valid_o      = valid_reg;
  assign frame_err_o  = frame_err_reg;
  assign parity_err_o = parity_err_reg;
  assign overrun_o    = overrun_reg;
  assign busy_o       = (state_reg != IDLE);

endmodule

// File: tb/tb_rs485_uart_rx.sv
// Directed bench for rs485_uart_rx: three instances (no, even, odd parity) at
// 16 cycles per bit, each with its own line and ready input.
module tb_rs485_uart_rx;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rx_line = 3'b111;
  logic [2:0] ready_line = 3'b111;
  logic [7:0] data_w [3];
  logic [2:0] valid_w, ferr_w, perr_w, ovr_w, busy_w;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      rs485_uart_rx #(
        .g_CyclesPerBit(N),
        .g_Parity      (gi)
      ) dut (
        .clk_ik      (clk),
        .rst_ir      (rst),
        .rx_i        (rx_line[gi]),
        .data_ob     (data_w[gi]),
        .valid_o     (valid_w[gi]),
        .ready_i     (ready_line[gi]),
        .frame_err_o (ferr_w[gi]),
        .parity_err_o(perr_w[gi]),
        .overrun_o   (ovr_w[gi]),
        .busy_o      (busy_w[gi])
      );
    end
  endgenerate

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: single writer for all counters, sampled on the falling edge.
  int         v_rise [3] = '{0, 0, 0};
  int         v_hi   [3] = '{0, 0, 0};
  int         fe_hi  [3] = '{0, 0, 0};
  int         pe_hi  [3] = '{0, 0, 0};
  int         ov_hi  [3] = '{0, 0, 0};
  int         both_hi[3] = '{0, 0, 0};
  int         rise_cyc[3] = '{0, 0, 0};
  logic [7:0] rise_data[3];
  logic [2:0] vprev = 3'b000;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (valid_w[i] && !vprev[i]) begin
        v_rise[i]++;
        rise_cyc[i]  = cyc;
        rise_data[i] = data_w[i];
      end
      if (valid_w[i]) v_hi[i]++;
      if (ferr_w[i]) fe_hi[i]++;
      if (perr_w[i]) pe_hi[i]++;
      if (ovr_w[i]) ov_hi[i]++;
      if (ferr_w[i] && perr_w[i]) both_hi[i]++;
    end
    vprev = valid_w;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int frame_t0 = 0;
  int s_rise, s_vhi, s_fe, s_pe, s_ov, s_both;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic snap(input int i);
    s_rise = v_rise[i];
    s_vhi  = v_hi[i];
    s_fe   = fe_hi[i];
    s_pe   = pe_hi[i];
    s_ov   = ov_hi[i];
    s_both = both_hi[i];
  endtask

  // Drives one frame starting now; caller is just past a falling clock edge.
  task automatic send_frame(input int i, input logic [7:0] d, input bit has_par,
                            input logic par, input logic stop);
    rx_line[i] = 1'b0;
    frame_t0   = cyc;
    repeat (N) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      rx_line[i] = d[b];
      repeat (N) @(negedge clk);
    end
    if (has_par) begin
      rx_line[i] = par;
      repeat (N) @(negedge clk);
    end
    rx_line[i] = stop;
    repeat (N) @(negedge clk);
    rx_line[i] = 1'b1;
    $display("[TB] dut%0d frame data=0x%02h par=%0d/%0b stop=%0b", i, d, has_par, par, stop);
  endtask

  initial begin
    // Reset state
    wait_cycles(3);
    check("rst_data",  32'(data_w[0]), 32'h00);
    check("rst_valid", 32'(valid_w[0]), 32'h0);
    check("rst_ferr",  32'(ferr_w[0]), 32'h0);
    check("rst_perr",  32'(perr_w[0]), 32'h0);
    check("rst_ovr",   32'(ovr_w[0]), 32'h0);
    check("rst_busy",  32'(busy_w[0]), 32'h0);
    rst = 1'b0;
    wait_cycles(6);

    // Basic 0xA5 frame, latency: valid rises H+9N+1 = 153 cycles after detect,
    // detect is 2 clock edges after the pin edge.
    snap(0);
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    wait_cycles(10);
    check("a5_rise",    32'(v_rise[0] - s_rise), 32'd1);
    check("a5_data",    32'(rise_data[0]), 32'hA5);
    check("a5_latency", 32'(rise_cyc[0] - frame_t0), 32'd155);
    check("a5_vhigh",   32'(v_hi[0] - s_vhi), 32'd1);
    check("a5_ferr",    32'(fe_hi[0] - s_fe), 32'd0);
    check("a5_perr",    32'(pe_hi[0] - s_pe), 32'd0);

    // 5-cycle low glitch: START sample at cycle 8 sees high, IDLE at cycle 9.
    snap(0);
    rx_line[0] = 1'b0;
    frame_t0   = cyc;
    wait_cycles(5);
    rx_line[0] = 1'b1;
    wait_cycles(5);
    check("glitch_busy_c8", 32'(busy_w[0]), 32'h1);
    wait_cycles(1);
    check("glitch_busy_c9", 32'(busy_w[0]), 32'h0);
    wait_cycles(20);
    check("glitch_valid", 32'(v_rise[0] - s_rise), 32'd0);
    check("glitch_ferr",  32'(fe_hi[0] - s_fe), 32'd0);
    $display("[TB] dut0 glitch 5 cycles");

    // Frame error on 0x3C, then a clean 0x81.
    snap(0);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    wait_cycles(20);
    check("ferr_pulse", 32'(fe_hi[0] - s_fe), 32'd1);
    check("ferr_valid", 32'(v_rise[0] - s_rise), 32'd0);
    snap(0);
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
    wait_cycles(10);
    check("x81_rise", 32'(v_rise[0] - s_rise), 32'd1);
    check("x81_data", 32'(rise_data[0]), 32'h81);

    // Even parity: 0x07 has three ones, correct parity bit is 1.
    snap(1);
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    wait_cycles(10);
    check("even_ok_rise", 32'(v_rise[1] - s_rise), 32'd1);
    check("even_ok_data", 32'(rise_data[1]), 32'h07);
    check("even_ok_perr", 32'(pe_hi[1] - s_pe), 32'd0);
    snap(1);
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
    wait_cycles(10);
    check("even_bad_perr", 32'(pe_hi[1] - s_pe), 32'd1);
    check("even_bad_rise", 32'(v_rise[1] - s_rise), 32'd0);
    snap(1);
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b0);
    wait_cycles(10);
    check("both_bad_same", 32'(both_hi[1] - s_both), 32'd1);
    check("both_bad_rise", 32'(v_rise[1] - s_rise), 32'd0);

    // Odd parity: correct parity bit for 0x07 is 0.
    snap(2);
    send_frame(2, 8'h07, 1'b1, 1'b0, 1'b1);
    wait_cycles(10);
    check("odd_ok_rise", 32'(v_rise[2] - s_rise), 32'd1);
    check("odd_ok_data", 32'(rise_data[2]), 32'h07);
    check("odd_ok_perr", 32'(pe_hi[2] - s_pe), 32'd0);
    snap(2);
    send_frame(2, 8'h07, 1'b1, 1'b1, 1'b1);
    wait_cycles(10);
    check("odd_bad_perr", 32'(pe_hi[2] - s_pe), 32'd1);
    check("odd_bad_rise", 32'(v_rise[2] - s_rise), 32'd0);

    // Overrun: three back-to-back frames with ready low.
    ready_line[0] = 1'b0;
    snap(0);
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'h33, 1'b0, 1'b0, 1'b1);
    wait_cycles(10);
    check("ovr_valid", 32'(valid_w[0]), 32'h1);
    check("ovr_data",  32'(data_w[0]), 32'h11);
    check("ovr_count", 32'(ov_hi[0] - s_ov), 32'd2);
    check("ovr_rise",  32'(v_rise[0] - s_rise), 32'd1);
    ready_line[0] = 1'b1;
    @(negedge clk);
    ready_line[0] = 1'b0;
    #1;
    check("ovr_consume", 32'(valid_w[0]), 32'h0);
    snap(0);
    send_frame(0, 8'h44, 1'b0, 1'b0, 1'b1);
    wait_cycles(10);
    check("x44_rise", 32'(v_rise[0] - s_rise), 32'd1);
    check("x44_data", 32'(rise_data[0]), 32'h44);
    check("x44_ovr",  32'(ov_hi[0] - s_ov), 32'd0);
    ready_line[0] = 1'b1;
    wait_cycles(5);

    // Reset during data bit 4 of 0x0F; the rest of the frame is low then high.
    snap(0);
    fork
      send_frame(0, 8'h0F, 1'b0, 1'b0, 1'b1);
      begin
        repeat (88) @(negedge clk);
        check("midrst_busy_before", 32'(busy_w[0]), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_data",  32'(data_w[0]), 32'h00);
        check("midrst_valid", 32'(valid_w[0]), 32'h0);
        check("midrst_busy",  32'(busy_w[0]), 32'h0);
        check("midrst_errs",  32'({ferr_w[0], perr_w[0], ovr_w[0]}), 32'h0);
        rst = 1'b0;
      end
    join
    wait_cycles(20);
    check("midrst_norx",  32'(v_rise[0] - s_rise), 32'd0);
    check("midrst_noerr", 32'(fe_hi[0] - s_fe), 32'd0);
    check("midrst_idle",  32'(busy_w[0]), 32'h0);
    snap(0);
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    wait_cycles(10);
    check("x5a_rise", 32'(v_rise[0] - s_rise), 32'd1);
    check("x5a_data", 32'(rise_data[0]), 32'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
